// File: rtl/debounce_timer_sched.sv
// rtl/debounce_timer_sched.sv - one debounce down-counter time-shared by N_CH debouncer channels
// Define DBNC_SCHED_FIXED_PRIO_EN for fixed lowest-index-wins arbitration (default: round-robin).
module debounce_timer_sched #(
  parameter int N_CH            = 4,
  parameter int COUNT_W         = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         timer_en,
  output logic [N_CH-1:0]         timer_done,
  output logic                    busy,
  output logic [$clog2(N_CH)-1:0] grant_id,
  output logic                    abort_pulse
);
  localparam int ID_W = $clog2(N_CH);
  localparam logic [COUNT_W-1:0] LOAD_VAL = COUNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [ID_W-1:0]    grant_q, grant_d;
  logic [N_CH-1:0]    done_q, done_d;
  logic               busy_q, busy_d;
  logic               abort_q, abort_d;
  logic [ID_W-1:0]    winner;
`ifndef DBNC_SCHED_FIXED_PRIO_EN
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    cand;
  logic               found;
`endif

  // Arbitration only matters in IDLE; non-owners are otherwise ignored.
  always_comb begin
    winner = '0;
`ifdef DBNC_SCHED_FIXED_PRIO_EN
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (timer_en[i]) winner = ID_W'(i);
    end
`else
    found = 1'b0;
    cand  = '0;
    for (int off = 1; off <= N_CH; off++) begin
      cand = ID_W'((int'(last_q) + off) % N_CH);
      if (!found && timer_en[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    grant_d = grant_q;
    abort_d = 1'b0;
`ifndef DBNC_SCHED_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|timer_en) begin
          grant_d = winner;
          count_d = LOAD_VAL;
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (!timer_en[grant_q]) begin
          abort_d = 1'b1;
`ifndef DBNC_SCHED_FIXED_PRIO_EN
          last_d  = grant_q;
`endif
          state_d = IDLE;
        end else if (count_q == '0) begin
          state_d = DONE;
        end else begin
          count_d = count_q - COUNT_W'(1);
        end
      end
      DONE: begin
`ifndef DBNC_SCHED_FIXED_PRIO_EN
        last_d  = grant_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Outputs are precomputed from next state so they come straight from flops.
    busy_d = (state_d != IDLE);
    done_d = '0;
    if (state_d == DONE) done_d[grant_d] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      abort_q <= 1'b0;
`ifndef DBNC_SCHED_FIXED_PRIO_EN
      last_q  <= ID_W'(N_CH - 1);
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      abort_q <= abort_d;
`ifndef DBNC_SCHED_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign timer_done  = done_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign abort_pulse = abort_q;

endmodule

// File: tb/tb_debounce_timer_sched.sv
// tb/tb_debounce_timer_sched.sv - scoreboard bench for debounce_timer_sched (N_CH=4, DEBOUNCE_CYCLES=4)
module tb_debounce_timer_sched;
  localparam int N_CH = 4;
  localparam int DC   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] timer_en;
  logic [3:0] timer_done;
  logic       busy;
  logic [1:0] grant_id;
  logic       abort_pulse;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  debounce_timer_sched #(
    .N_CH(N_CH),
    .COUNT_W(16),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .timer_en(timer_en),
    .timer_done(timer_done),
    .busy(busy),
    .grant_id(grant_id),
    .abort_pulse(abort_pulse)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    timer_en = 4'b0000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (grant_id !== 2'd0) $display("FAIL reset_grant_id: got %0d want 0", grant_id); else n_pass++;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_checks++;
      if (timer_done !== 4'b0000) $display("FAIL reset_done c%0d: got %b want 0000", c, timer_done); else n_pass++;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL reset_busy c%0d: got %b want 0", c, busy); else n_pass++;
      n_checks++;
      if (abort_pulse !== 1'b0) $display("FAIL reset_abort c%0d: got %b want 0", c, abort_pulse); else n_pass++;
    end
  endtask

  task automatic test_single();
    int e;
    do_reset();
    timer_en = 4'b0001;
    exp_q.push_back(0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      n_checks++;
      if (busy !== (c <= DC + 1)) $display("FAIL single_busy c%0d: got %b want %b", c, busy, (c <= DC + 1)); else n_pass++;
      if (timer_done !== 4'b0000) begin
        n_checks++;
        if (c != DC + 1) $display("FAIL single_latency: done at c%0d want c%0d", c, DC + 1); else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL single_spurious_done: got %b want 0000", timer_done);
        else begin
          e = exp_q.pop_front();
          if (timer_done !== 4'(1 << e)) $display("FAIL single_done: got %b want %b", timer_done, 4'(1 << e)); else n_pass++;
        end
        timer_en = 4'b0000;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL single_missing_done: got none want %0d pending", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_round_robin();
    int e;
    int cyc;
    int last_done;
    do_reset();
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back(0);
    exp_q.push_back(1);
    exp_q.push_back(2);
    exp_q.push_back(3);
    exp_q.push_back(0);
    timer_en = 4'b1111;
    cyc = 0;
    last_done = -1;
    while (exp_q.size() > 0 && cyc < 60) begin
      tick();
      cyc++;
      if (timer_done !== 4'b0000) begin
        e = exp_q.pop_front();
        n_checks++;
        if (timer_done !== 4'(1 << e)) $display("FAIL rr_done: got %b want %b", timer_done, 4'(1 << e)); else n_pass++;
        n_checks++;
        if (grant_id !== 2'(e)) $display("FAIL rr_grant_id: got %0d want %0d", grant_id, e); else n_pass++;
        if (last_done >= 0) begin
          n_checks++;
          if (cyc - last_done != DC + 2) $display("FAIL rr_gap: got %0d want %0d", cyc - last_done, DC + 2); else n_pass++;
        end
        last_done = cyc;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL rr_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
    timer_en = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_abort();
    int e;
    bit seen;
    do_reset();
    timer_en = 4'b0100;
    tick();
    n_checks++;
    if (busy !== 1'b1 || grant_id !== 2'd2) $display("FAIL abort_grant: got busy=%b id=%0d want busy=1 id=2", busy, grant_id); else n_pass++;
    tick();
    timer_en = 4'b1011;
    tick();
    n_checks++;
    if (abort_pulse !== 1'b1) $display("FAIL abort_pulse: got %b want 1", abort_pulse); else n_pass++;
    n_checks++;
    if (busy !== 1'b0 || timer_done !== 4'b0000) $display("FAIL abort_state: got busy=%b done=%b want busy=0 done=0000", busy, timer_done); else n_pass++;
    exp_q.push_back(3);
    tick();
    n_checks++;
    if (abort_pulse !== 1'b0) $display("FAIL abort_pulse_width: got %b want 0", abort_pulse); else n_pass++;
    n_checks++;
    if (busy !== 1'b1 || grant_id !== 2'd3) $display("FAIL abort_next_grant: got busy=%b id=%0d want busy=1 id=3", busy, grant_id); else n_pass++;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (timer_done !== 4'b0000) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        n_checks++;
        if (timer_done !== 4'(1 << e)) $display("FAIL abort_done: got %b want %b", timer_done, 4'(1 << e)); else n_pass++;
        timer_en = 4'b0000;
      end
    end
    n_checks++;
    if (!seen) begin
      $display("FAIL abort_timeout: got no done want %b", 4'b1000);
      exp_q.delete();
    end else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_reset_mid_count();
    int e;
    do_reset();
    timer_en = 4'b0001;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || timer_done !== 4'b0000 || abort_pulse !== 1'b0)
      $display("FAIL midrst_state: got busy=%b done=%b abort=%b want 0/0000/0", busy, timer_done, abort_pulse);
    else n_pass++;
    exp_q.push_back(0);
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (timer_done !== 4'b0000) begin
        n_checks++;
        if (c != DC + 1) $display("FAIL midrst_latency: done at c%0d want c%0d", c, DC + 1); else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL midrst_spurious_done: got %b want 0000", timer_done);
        else begin
          e = exp_q.pop_front();
          if (timer_done !== 4'(1 << e)) $display("FAIL midrst_done: got %b want %b", timer_done, 4'(1 << e)); else n_pass++;
        end
        timer_en = 4'b0000;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL midrst_missing_done: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
  endtask

  task automatic test_transient_request();
    int e;
    bit seen;
    do_reset();
    timer_en = 4'b0001;
    exp_q.push_back(0);
    tick();
    timer_en = 4'b1001;
    tick();
    timer_en = 4'b0001;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (timer_done !== 4'b0000) begin
        seen = 1'b1;
        e = exp_q.pop_front();
        n_checks++;
        if (timer_done !== 4'(1 << e)) $display("FAIL transient_done: got %b want %b", timer_done, 4'(1 << e)); else n_pass++;
        timer_en = 4'b0000;
      end
    end
    n_checks++;
    if (!seen) begin
      $display("FAIL transient_timeout: got no done want 0001");
      exp_q.delete();
    end else n_pass++;
    for (int c = 0; c < 6; c++) begin
      tick();
      n_checks++;
      if (busy !== 1'b0 || timer_done !== 4'b0000) $display("FAIL transient_trace c%0d: got busy=%b done=%b want 0/0000", c, busy, timer_done); else n_pass++;
    end
  endtask

  task automatic test_two_requesters();
    int e;
    int cyc;
    do_reset();
`ifdef DBNC_SCHED_FIXED_PRIO_EN
    exp_q.push_back(1);
    exp_q.push_back(1);
    exp_q.push_back(1);
`else
    exp_q.push_back(1);
    exp_q.push_back(3);
    exp_q.push_back(1);
`endif
    timer_en = 4'b1010;
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 40) begin
      tick();
      cyc++;
      if (timer_done !== 4'b0000) begin
        e = exp_q.pop_front();
        n_checks++;
        if (timer_done !== 4'(1 << e)) $display("FAIL two_req_done: got %b want %b", timer_done, 4'(1 << e)); else n_pass++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL two_req_timeout: got %0d pending want 0", exp_q.size());
      exp_q.delete();
    end else n_pass++;
    timer_en = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    timer_en = 4'b0000;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_reset_mid_count();
    test_transient_request();
    test_two_requesters();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
